// File: rtl/pfxsum_sched.sv
// rtl/pfxsum_sched.sv - round-robin job scheduler in front of a prefix-sum engine
//
// Accepts one vector at a time from N_REQ requesters (round-robin from rr_ptr),
// launches it to the engine, waits at least MIN_LAT cycles for the engine done
// flag, then returns the engine result to the owning requester.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester handshake (ready is one-hot, IDLE only)
//   req_vec                   packed request vectors, requester i in slice i
//   resp_valid                one-hot single-cycle result strobe to the owner
//   resp_vec, resp_err        result vector and timeout flag, qualified by resp_valid
//   eng_valid_in, eng_ivec    launch pulse and vector to the engine
//   eng_valid_out, eng_ovec   engine done level and result
//   busy                      high whenever not IDLE
//
// Optional feature macro: PFXSCHED_TIMEOUT_EN (WAIT gives up after TIMEOUT cycles).
module pfxsum_sched #(
    parameter int IWIDTH  = 8,
    parameter int V_LEN   = 16,
    parameter int N_REQ   = 4,
    parameter int MIN_LAT = 2 * $clog2(V_LEN) + 3,
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*V_LEN*IWIDTH-1:0] req_vec,
    output logic [N_REQ-1:0]            resp_valid,
    output logic [V_LEN*IWIDTH-1:0]     resp_vec,
    output logic                        resp_err,
    output logic                        eng_valid_in,
    output logic [V_LEN*IWIDTH-1:0]     eng_ivec,
    input  logic                        eng_valid_out,
    input  logic [V_LEN*IWIDTH-1:0]     eng_ovec,
    output logic                        busy
);
    localparam int VW   = V_LEN * IWIDTH;
    localparam int PW   = $clog2(N_REQ);
    localparam int CMAX = (MIN_LAT > TIMEOUT) ? MIN_LAT : TIMEOUT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t          state;
    state_t          next_state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [CW-1:0]   wait_cnt;

    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [VW-1:0]   gnt_vec;
    int              idx;
    logic            done_hit;

    // Round-robin pick: scan offsets from the highest down so the last match
    // written is the one closest to rr_ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        idx     = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % N_REQ;
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
                gnt_vec = req_vec[idx*VW +: VW];
            end
        end
    end

    // The done flag is a sticky level, so a flag left over from the previous
    // job is only trusted once the engine has had MIN_LAT cycles.
    assign done_hit = eng_valid_out && (wait_cnt >= CW'(MIN_LAT));

`ifdef PFXSCHED_TIMEOUT_EN
    logic tmo_hit;
    logic err_q;
    assign tmo_hit  = !done_hit && (wait_cnt >= CW'(TIMEOUT));
    assign resp_err = err_q && (state == RESP);
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        req_ready    = '0;
        resp_valid   = '0;
        eng_valid_in = 1'b0;
        busy         = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (gnt_any && !rst) begin
                    req_ready = N_REQ'(1) << gnt_idx;
                end
                if (gnt_any) begin
                    next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                eng_valid_in = 1'b1;
                next_state   = WAIT;
            end
            WAIT: begin
                if (done_hit) begin
                    next_state = RESP;
`ifdef PFXSCHED_TIMEOUT_EN
                end else if (tmo_hit) begin
                    next_state = RESP;
`endif
                end
            end
            RESP: begin
                resp_valid = N_REQ'(1) << owner;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            owner    <= '0;
            wait_cnt <= '0;
            eng_ivec <= '0;
            resp_vec <= '0;
`ifdef PFXSCHED_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        owner    <= gnt_idx;
                        eng_ivec <= gnt_vec;
                        rr_ptr   <= (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                LAUNCH: wait_cnt <= '0;
                WAIT: begin
                    if (wait_cnt != {CW{1'b1}}) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    if (done_hit) begin
                        resp_vec <= eng_ovec;
`ifdef PFXSCHED_TIMEOUT_EN
                        err_q    <= 1'b0;
                    end else if (tmo_hit) begin
                        resp_vec <= '0;
                        err_q    <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_pfxsum_sched.sv
// tb/tb_pfxsum_sched.sv - self-checking bench for pfxsum_sched with a behavioural engine
module tb_pfxsum_sched;
    localparam int IW = 8;
    localparam int VL = 16;
    localparam int NR = 4;
    localparam int ML = 2 * $clog2(VL) + 3;
    localparam int TO = 64;
    localparam int VW = VL * IW;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR-1:0]      req_ready;
    logic [NR*VW-1:0]   req_vec;
    logic [NR-1:0]      resp_valid;
    logic [VW-1:0]      resp_vec;
    logic               resp_err;
    logic               eng_valid_in;
    logic [VW-1:0]      eng_ivec;
    logic               eng_valid_out;
    logic [VW-1:0]      eng_ovec;
    logic               busy;

    logic [VW-1:0]      vecs [NR];
    int                 total = 0;
    int                 bad = 0;
    int                 cyc = 0;
    int                 resp_cnt [NR] = '{default: 0};
    int                 exp_resp [NR] = '{default: 0};
    int                 last_resp = 0;
    bit                 b2b = 1'b0;

    // engine model state
    logic               eng_done;
    logic               eng_hold0 = 1'b0;
    int                 eng_lat = ML;
    logic               epend;
    int                 ecnt;
    logic [VW-1:0]      ein;

    always #5 clk = ~clk;

    pfxsum_sched #(.IWIDTH(IW), .V_LEN(VL), .N_REQ(NR), .MIN_LAT(ML), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vec(req_vec),
        .resp_valid(resp_valid), .resp_vec(resp_vec), .resp_err(resp_err),
        .eng_valid_in(eng_valid_in), .eng_ivec(eng_ivec),
        .eng_valid_out(eng_valid_out), .eng_ovec(eng_ovec),
        .busy(busy)
    );

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < NR; i++) req_vec[i*VW +: VW] = vecs[i];
    end

    // exclusive prefix sum, wrapping at IW bits
    function automatic logic [VW-1:0] pfx(input logic [VW-1:0] v);
        logic [VW-1:0] o;
        logic [IW-1:0] acc;
        o = '0;
        acc = '0;
        for (int k = 0; k < VL; k++) begin
            o[k*IW +: IW] = acc;
            acc = acc + v[k*IW +: IW];
        end
        return o;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < VL; k++) v[k*IW +: IW] = IW'($urandom);
        return v;
    endfunction

    // engine: result appears eng_lat cycles after launch; done is sticky
    always @(posedge clk) begin
        if (rst) begin
            eng_done <= 1'b0;
            epend    <= 1'b0;
            ecnt     <= 0;
            eng_ovec <= '0;
            ein      <= '0;
        end else if (eng_valid_in) begin
            epend <= 1'b1;
            ecnt  <= eng_lat;
            ein   <= eng_ivec;
        end else if (epend) begin
            if (ecnt <= 1) begin
                epend    <= 1'b0;
                eng_done <= 1'b1;
                eng_ovec <= pfx(ein);
            end else begin
                ecnt <= ecnt - 1;
            end
        end
    end
    assign eng_valid_out = eng_done & ~eng_hold0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NR; i++)
            if (resp_valid[i]) resp_cnt[i] <= resp_cnt[i] + 1;
    end

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input bit check);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        if (check) begin
            chk("rst_busy", VW'(busy), VW'(0));
            chk("rst_ready", VW'(req_ready), VW'(0));
            chk("rst_resp_valid", VW'(resp_valid), VW'(0));
            chk("rst_resp_err", VW'(resp_err), VW'(0));
            chk("rst_eng_valid_in", VW'(eng_valid_in), VW'(0));
            chk("rst_resp_vec", resp_vec, VW'(0));
            chk("rst_eng_ivec", eng_ivec, VW'(0));
        end
        rst = 1'b0;
    endtask

    // caller drives inputs just after a falling edge, then calls this
    task automatic wait_grant(output bit ok);
        int k;
        k = 0;
        #1;
        while (((req_valid & req_ready) == '0) && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        ok = (k < 200);
        chk("grant_seen", VW'(ok), VW'(1));
    endtask

    task automatic run_job(input int owner, input int lat, input logic [NR-1:0] clr, input bit err);
        bit ok;
        int g;
        int k;
        int stray;
        logic [VW-1:0] vin;
        logic [VW-1:0] vexp;
        wait_grant(ok);
        if (!ok) return;
        chk("grant_owner", VW'(req_ready), VW'(NR'(1) << owner));
        vin  = vecs[owner];
        vexp = err ? '0 : pfx(vin);
        g = cyc;
        if (b2b) chk("b2b_gap", VW'(g - last_resp), VW'(1));
        @(negedge clk);
        req_valid = req_valid & ~clr;
        vecs[owner] = rand_vec();
        #1;
        chk("launch_pulse", VW'(eng_valid_in), VW'(1));
        chk("launch_vec", eng_ivec, vin);
        chk("busy_launch", VW'(busy), VW'(1));
        @(negedge clk);
        #1;
        chk("launch_single", VW'(eng_valid_in), VW'(0));
        k = 0;
        stray = 0;
        while (resp_valid == '0 && k < 400) begin
            if (req_ready != '0 || busy !== 1'b1) stray++;
            @(negedge clk);
            #1;
            k++;
        end
        chk("resp_seen", VW'(k < 400), VW'(1));
        chk("wait_ready_busy", VW'(stray), VW'(0));
        chk("latency", VW'(cyc - g), VW'(lat));
        chk("resp_owner", VW'(resp_valid), VW'(NR'(1) << owner));
        chk("resp_vec", resp_vec, vexp);
        chk("resp_err", VW'(resp_err), VW'(err));
        chk("eng_ivec_hold", eng_ivec, vin);
        last_resp = cyc;
        exp_resp[owner]++;
        @(negedge clk);
        #1;
        chk("resp_single", VW'(resp_valid), VW'(0));
        chk("idle_busy", VW'(busy), VW'(0));
    endtask

    initial begin
        bit ok;
        int rc;
        int viol;
        for (int i = 0; i < NR; i++) vecs[i] = '0;

        // reset state, then idle with nothing requested
        do_reset(1'b1);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("idle_noreq_busy", VW'(busy), VW'(0));
            chk("idle_noreq_ready", VW'(req_ready), VW'(0));
        end

        // requester 0 sends 1..16
        @(negedge clk);
        for (int k = 0; k < VL; k++) vecs[0][k*IW +: IW] = IW'(k + 1);
        req_valid = 4'b0001;
        eng_lat = ML;
        run_job(0, ML + 3, 4'b0001, 1'b0);

        // rr_ptr=1 must survive idle cycles: {0,1} valid -> 1
        repeat (4) @(negedge clk);
        vecs[0] = rand_vec();
        vecs[1] = rand_vec();
        req_valid = 4'b0011;
        eng_lat = $urandom_range(1, ML);
        run_job(1, ML + 3, 4'b0011, 1'b0);

        // engine slower than MIN_LAT on a fresh job
        do_reset(1'b0);
        vecs[2] = rand_vec();
        req_valid = 4'b0100;
        eng_lat = ML + 5;
        run_job(2, ML + 8, 4'b0100, 1'b0);

        // all four held valid from reset: order 0,1,2,3,0 back to back
        do_reset(1'b0);
        for (int i = 0; i < NR; i++) vecs[i] = rand_vec();
        req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            eng_lat = $urandom_range(1, ML);
            b2b = (j != 0);
            run_job(j % NR, ML + 3, 4'b0000, 1'b0);
        end
        b2b = 1'b0;
        req_valid = 4'b0000;

        // stale done flag high from the previous job
        @(negedge clk);
        vecs[1] = rand_vec();
        req_valid = 4'b0010;
        eng_lat = ML;
        run_job(1, ML + 3, 4'b0010, 1'b0);

        // reset during WAIT for requester 2 (rr_ptr would be 3 afterwards)
        @(negedge clk);
        vecs[2] = rand_vec();
        req_valid = 4'b0100;
        wait_grant(ok);
        chk("abandon_owner", VW'(req_ready), VW'(4'b0100));
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (4) @(negedge clk);
        #1;
        chk("abandon_in_wait", VW'(busy), VW'(1));
        rc = resp_cnt[2];
        vecs[1] = rand_vec();
        vecs[3] = rand_vec();
        req_valid = 4'b1010;
        do_reset(1'b1);
        chk("abandon_no_resp", VW'(resp_cnt[2]), VW'(rc));
        eng_lat = ML;
        // requester 1 wins from rr_ptr=0; requester 3 drops during service
        run_job(1, ML + 3, 4'b1010, 1'b0);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("no_spurious_grant", VW'(req_ready), VW'(0));
            chk("no_spurious_busy", VW'(busy), VW'(0));
        end
        @(negedge clk);
        req_valid = 4'b1000;
        eng_lat = $urandom_range(1, ML);
        run_job(3, ML + 3, 4'b1000, 1'b0);

        // engine never finishes
        do_reset(1'b0);
        eng_hold0 = 1'b1;
        vecs[0] = rand_vec();
        req_valid = 4'b0001;
`ifdef PFXSCHED_TIMEOUT_EN
        run_job(0, TO + 3, 4'b0001, 1'b1);
`else
        wait_grant(ok);
        @(negedge clk);
        req_valid = 4'b0000;
        viol = 0;
        repeat (200) begin
            @(negedge clk);
            #1;
            if (busy !== 1'b1 || resp_valid != '0) viol++;
        end
        chk("hang_busy", VW'(viol), VW'(0));
        do_reset(1'b0);
`endif
        eng_hold0 = 1'b0;

        @(negedge clk);
        #1;
        for (int i = 0; i < NR; i++) chk("resp_count", VW'(resp_cnt[i]), VW'(exp_resp[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pfxsum_sched.md
PFXSUM_SCHED -- requirements
Module: pfxsum_sched

Interface
- REQ-001 Parameter IWIDTH, default 8, integer width in bits.
- REQ-002 Parameter V_LEN, default 16, vector length (power of two, >=2).
- REQ-003 Parameter N_REQ, default 4, number of requesters (2..8).
- REQ-004 Parameter MIN_LAT, default 2*$clog2(V_LEN)+3, minimum cycles from launch before engine output is accepted.
- REQ-005 Parameter TIMEOUT, default 64, maximum wait cycles (used only under PFXSCHED_TIMEOUT_EN).
- REQ-006 clk  input  1  sole clock; all logic on rising edge.
- REQ-007 rst  input  1  synchronous, active-high reset.
- REQ-008 req_valid  input  N_REQ  per-requester request strobe.
- REQ-009 req_ready  output  N_REQ  one-hot grant/accept; a transfer occurs when valid and ready are both high.
- REQ-010 req_vec  input  N_REQ*V_LEN*IWIDTH  packed input vectors; requester i occupies slice i.
- REQ-011 resp_valid  output  N_REQ  one-hot, single-cycle result strobe to the owning requester.
- REQ-012 resp_vec  output  V_LEN*IWIDTH  result vector, valid while any resp_valid bit is high.
- REQ-013 resp_err  output  1  result invalid (timeout); qualified by resp_valid.
- REQ-014 eng_valid_in  output  1  single-cycle launch pulse to the prefix-sum engine.
- REQ-015 eng_ivec  output  V_LEN*IWIDTH  vector to the engine.
- REQ-016 eng_valid_out  input  1  engine done flag (level; stays high once set).
- REQ-017 eng_ovec  input  V_LEN*IWIDTH  engine result.
- REQ-018 busy  output  1  high in every state except IDLE.

Function
- REQ-019 The FSM SHALL have states IDLE, LAUNCH, WAIT and RESP.
- REQ-020 IDLE: with any req_valid high, the scheduler SHALL grant one requester round-robin, starting at rr_ptr; it SHALL assert that requester's req_ready in the same cycle (combinational on req_valid and rr_ptr), latch its vector and index, and go to LAUNCH.
- REQ-021 After each grant, rr_ptr SHALL become (granted index + 1) mod N_REQ.
- REQ-022 req_ready SHALL be zero outside IDLE; a request is never dropped and SHALL be held by the requester until it is granted.
- REQ-023 LAUNCH: eng_valid_in SHALL be 1 for exactly one cycle, with eng_ivec equal to the latched vector; the FSM then goes to WAIT and clears wait_cnt.
- REQ-024 WAIT: wait_cnt SHALL increment each cycle and saturate. Exit to RESP occurs when eng_valid_out=1 and wait_cnt>=MIN_LAT, which ignores the stale done flag from the previous job.
- REQ-025 RESP: resp_valid[owner] SHALL be 1 for one cycle, with resp_vec equal to eng_ovec as registered on the WAIT exit cycle and resp_err=0; the FSM then returns to IDLE.
- REQ-026 Grant-to-response latency SHALL be MIN_LAT+3 cycles when the engine is already done at MIN_LAT.
- REQ-027 Back-to-back requests: the earliest next grant SHALL be the cycle after RESP; there is no overlap of jobs.
- REQ-028 eng_ivec SHALL hold the latched vector until the next grant.
- REQ-029 When all req_valid bits are 0 in IDLE, the FSM SHALL remain in IDLE and rr_ptr SHALL be unchanged.

Reset
- REQ-030 rst=1 at any clock edge SHALL force IDLE and set rr_ptr=0, wait_cnt=0, req_ready=0, resp_valid=0, resp_err=0, eng_valid_in=0, busy=0, resp_vec=0 and eng_ivec=0.
- REQ-031 Reset during LAUNCH, WAIT or RESP SHALL abandon the job with no resp_valid.
- REQ-032 After reset, the first grant SHALL be evaluated on the first cycle with rst=0.

Configuration
- REQ-033 With PFXSCHED_TIMEOUT_EN defined: if wait_cnt reaches TIMEOUT in WAIT without completing, the FSM SHALL go to RESP with resp_err=1 and resp_vec=0.
- REQ-034 Without PFXSCHED_TIMEOUT_EN: WAIT SHALL last indefinitely, resp_err SHALL be tied to 0, and no timeout logic SHALL exist.

Verification
- REQ-035 Single request: requester 0 sends vector 1..16, IWIDTH=8 -> resp_valid=4'b0001 and resp_vec = exclusive prefix sums 0,1,3,6,...,120.
- REQ-036 All four requesters held valid from reset -> grant order is 0,1,2,3,0, with exactly one resp_valid per job to the matching owner.
- REQ-037 eng_valid_out stuck high from the previous job -> no RESP before wait_cnt reaches MIN_LAT; latency equals MIN_LAT+3.
- REQ-038 rst pulsed during WAIT for requester 2 -> no resp_valid, busy=0 the next cycle, and the next grant goes to the lowest valid index from rr_ptr=0.
- REQ-039 With PFXSCHED_TIMEOUT_EN and eng_valid_out held 0 -> resp_err=1 and resp_vec=0 exactly TIMEOUT+2 cycles after launch; without the macro, busy stays 1 indefinitely.
- REQ-040 Requester 3 drops req_valid while requester 1 is being serviced, then reasserts -> requester 3 is granted after requester 1's RESP, and no spurious grant occurs while it is low.
